// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART program-image loader feeding the core's instruction memory
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]   MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, DONE, ERR} ld_state_t;

  // rxd_d is one stage behind the synchroniser output, for start-edge detection
  logic rxd_m, rxd_s, rxd_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          cnt_clr, shift_bit, byte_valid, framing_err;

  always_comb begin
    rx_next     = rx_state;
    cnt_clr     = 1'b0;
    shift_bit   = 1'b0;
    byte_valid  = 1'b0;
    framing_err = 1'b0;
    case (rx_state)
      RX_IDLE: if (rxd_d && !rxd_s) begin
        rx_next = RX_START;
        cnt_clr = 1'b1;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        cnt_clr = 1'b1;
        rx_next = rxd_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        cnt_clr   = 1'b1;
        shift_bit = 1'b1;
        if (bit_idx == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_next     = RX_IDLE;
        byte_valid  = rxd_s;
        framing_err = !rxd_s;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= cnt_clr ? '0 : rx_cnt + 1'b1;
      if (rx_state == RX_IDLE) bit_idx <= '0;
      if (shift_bit) begin
        rx_byte <= {rxd_s, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  ld_state_t     ld_state, ld_next;
  logic [7:0]    n_lo;
  logic [ADDR_W:0] n_words, word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   word_acc;
  logic [15:0]   hdr_n;
  logic          last_write;

  assign hdr_n      = {rx_byte, n_lo};
  assign last_write = mem_we && ((word_idx + 1'b1) == n_words);

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      HDR_LO: begin
        if (framing_err)     ld_next = ERR;
        else if (byte_valid) ld_next = HDR_HI;
      end
      HDR_HI: begin
        if (framing_err) ld_next = ERR;
        else if (byte_valid) begin
          if (hdr_n == 16'd0)                 ld_next = DONE;
          else if ({1'b0, hdr_n} > MAX_WORDS) ld_next = ERR;
          else                                ld_next = DATA;
        end
      end
      DATA: begin
        if (framing_err)     ld_next = ERR;
        else if (last_write) ld_next = DONE;
      end
      DONE:    ld_next = DONE;
      ERR:     ld_next = ERR;
      default: ld_next = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_state  <= HDR_LO;
      n_lo      <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word_acc  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      ld_state <= ld_next;
      mem_we   <= 1'b0;
      if (ld_state == HDR_LO && byte_valid) n_lo <= rx_byte;
      if (ld_state == HDR_HI && byte_valid) n_words <= hdr_n[ADDR_W:0];
      // big-endian assembly: the fourth byte completes the word and schedules the write
      if (ld_state == DATA && byte_valid) begin
        word_acc <= {word_acc[15:0], rx_byte};
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) begin
          mem_we    <= 1'b1;
          mem_wdata <= {word_acc, rx_byte};
        end
      end
      if (mem_we) begin
        word_idx <= word_idx + 1'b1;
        mem_addr <= mem_addr + 1'b1;
      end
    end
  end

  assign cpu_rst = (ld_state != DONE);
  assign done    = (ld_state == DONE);
  assign err     = (ld_state == ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed self-checking bench for uart_boot_loader
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, cpu_rst, done, err;

  uart_boot_loader #(.CLKS_PER_BIT(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  int          cyc = 0;
  int          we_total = 0;
  int          last_we_cyc = -1;
  int          done_rise_cyc = -2;
  int          hold_bad = 0;
  logic        done_prev = 1'b0;
  logic        chk_en = 1'b0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      we_total++;
      last_we_cyc = cyc;
      wr_addr_q.push_back(32'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = done;
    if (chk_en && (cpu_rst !== ~done)) hold_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clk(4);
    end
    rxd = stop_bit;
    wait_clk(4);
    rxd = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(2);
  endtask

  int base;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // two-word image
    base = we_total;
    send_hdr(16'h0002);
    send_word(32'hAABBCCDD);
    check("t1_mid_cpu_rst", 32'(cpu_rst), 32'h1);
    send_word(32'h11223344);
    wait_clk(4);
    check("t1_wr_count", 32'(we_total - base), 32'd2);
    check("t1_addr0", wr_addr_q[base], 32'h0);
    check("t1_data0", wr_data_q[base], 32'hAABBCCDD);
    check("t1_addr1", wr_addr_q[base+1], 32'h1);
    check("t1_data1", wr_data_q[base+1], 32'h11223344);
    check("t1_done", 32'(done), 32'h1);
    check("t1_cpu_rst", 32'(cpu_rst), 32'h0);
    check("t1_err", 32'(err), 32'h0);
    check("t1_done_latency", 32'(done_rise_cyc - last_we_cyc), 32'd1);
    send_word(32'h01020304);
    check("t1_ignored_after_done", 32'(we_total - base), 32'd2);
    check("t1_done_sticky", 32'(done), 32'h1);

    // empty image
    do_reset();
    check("t2_rst_wdata", mem_wdata, 32'h0);
    check("t2_rst_addr", 32'(mem_addr), 32'h0);
    base = we_total;
    send_hdr(16'h0000);
    check("t2_wr_count", 32'(we_total - base), 32'd0);
    check("t2_done", 32'(done), 32'h1);
    check("t2_cpu_rst", 32'(cpu_rst), 32'h0);
    check("t2_err", 32'(err), 32'h0);

    // oversize count: 17 > 16
    do_reset();
    base = we_total;
    send_hdr(16'h0011);
    check("t3_err", 32'(err), 32'h1);
    check("t3_cpu_rst", 32'(cpu_rst), 32'h1);
    send_word(32'hAABBCCDD);
    check("t3_wr_count", 32'(we_total - base), 32'd0);
    check("t3_err_sticky", 32'(err), 32'h1);
    check("t3_done", 32'(done), 32'h0);

    // framing error in data, then recovery after reset
    do_reset();
    base = we_total;
    send_hdr(16'h0001);
    send_byte(8'h55, 1'b0);
    check("t4_err", 32'(err), 32'h1);
    check("t4_cpu_rst", 32'(cpu_rst), 32'h1);
    check("t4_wr_count", 32'(we_total - base), 32'd0);
    do_reset();
    check("t4_err_cleared", 32'(err), 32'h0);
    base = we_total;
    send_hdr(16'h0001);
    send_word(32'hDEADBEEF);
    check("t4_wr_count2", 32'(we_total - base), 32'd1);
    check("t4_addr0", wr_addr_q[base], 32'h0);
    check("t4_data0", wr_data_q[base], 32'hDEADBEEF);
    check("t4_done", 32'(done), 32'h1);

    // one-cycle glitch must not be taken as a start bit
    do_reset();
    base = we_total;
    rxd = 1'b0;
    wait_clk(1);
    rxd = 1'b1;
    wait_clk(12);
    check("t5_glitch_err", 32'(err), 32'h0);
    check("t5_glitch_done", 32'(done), 32'h0);
    send_hdr(16'h0001);
    send_word(32'h12345678);
    check("t5_wr_count", 32'(we_total - base), 32'd1);
    check("t5_addr0", wr_addr_q[base], 32'h0);
    check("t5_data0", wr_data_q[base], 32'h12345678);
    check("t5_done", 32'(done), 32'h1);

    // reset mid-word discards the partial word
    do_reset();
    base = we_total;
    send_hdr(16'h0001);
    send_byte(8'hCA, 1'b1);
    send_byte(8'hFE, 1'b1);
    check("t6_mid_cpu_rst", 32'(cpu_rst), 32'h1);
    do_reset();
    send_hdr(16'h0001);
    send_word(32'hCAFEBABE);
    check("t6_wr_count", 32'(we_total - base), 32'd1);
    check("t6_addr0", wr_addr_q[base], 32'h0);
    check("t6_data0", wr_data_q[base], 32'hCAFEBABE);
    check("t6_done", 32'(done), 32'h1);

    // full memory: N == 16 is legal, last write at address 15
    do_reset();
    base = we_total;
    send_hdr(16'h0010);
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      b = 8'(k);
      send_word({b, b, b, b});
      if (k == 14) check("t7_not_done_before_last", 32'(done), 32'h0);
    end
    wait_clk(4);
    check("t7_wr_count", 32'(we_total - base), 32'd16);
    check("t7_addr0", wr_addr_q[base], 32'h0);
    check("t7_addr15", wr_addr_q[base+15], 32'hF);
    check("t7_data15", wr_data_q[base+15], 32'h0F0F0F0F);
    check("t7_done", 32'(done), 32'h1);
    check("t7_err", 32'(err), 32'h0);

    check("cpu_rst_vs_done_cycles", 32'(hold_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
